// File: rtl/serial_twos_comp_n.sv
// Multi-channel, LSB-first bit-serial two's complementer with word framing and mode latch.
// Define SERIAL_TC_PAR_OUT_EN to add the par_out word assembly and ovf flags.
module serial_twos_comp_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 1,
    parameter int CNT_W    = $clog2(WIDTH)
) (
    input  logic                      t_clk,
    input  logic                      r,
    input  logic [CHANNELS-1:0]       i,
    input  logic                      in_valid,
    input  logic                      sof,
    input  logic                      mode,
    output logic [CHANNELS-1:0]       y,
    output logic                      out_valid,
    output logic [CNT_W-1:0]          bit_idx,
    output logic                      word_done
`ifdef SERIAL_TC_PAR_OUT_EN
    ,
    output logic [CHANNELS*WIDTH-1:0] par_out,
    output logic [CHANNELS-1:0]       ovf
`endif
);

    // Handshake: in_valid qualifies i/sof/mode on the same edge; out_valid is in_valid
    // delayed one cycle and marks y/bit_idx/word_done as fresh. There is no backpressure.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cur_idx;
    logic [CNT_W-1:0]    cnt_next;
    logic                first_bit;
    logic                last_bit;
    logic                mode_q;
    logic                mode_eff;
    logic [CHANNELS-1:0] seen_q;
    logic [CHANNELS-1:0] seen_prev;
    logic [CHANNELS-1:0] seen_next;
    logic [CHANNELS-1:0] y_next;

    always_comb begin
        cur_idx   = sof ? '0 : cnt;
        first_bit = (cur_idx == '0);
        last_bit  = (cur_idx == LAST);
        cnt_next  = last_bit ? '0 : cur_idx + CNT_W'(1);
        // Mode is taken live on bit 0 so the first bit already uses the new word's mode.
        mode_eff  = first_bit ? mode : mode_q;
        seen_prev = first_bit ? '0 : seen_q;
        y_next    = i ^ (seen_prev & {CHANNELS{mode_eff}});
        seen_next = last_bit ? '0 : (seen_prev | i);
    end

    always_ff @(posedge t_clk) begin
        if (!r) begin
            cnt       <= '0;
            seen_q    <= '0;
            mode_q    <= 1'b0;
            y         <= '0;
            out_valid <= 1'b0;
            bit_idx   <= '0;
            word_done <= 1'b0;
        end else begin
            out_valid <= in_valid;
            word_done <= in_valid && last_bit;
            if (in_valid) begin
                cnt     <= cnt_next;
                seen_q  <= seen_next;
                y       <= y_next;
                bit_idx <= cur_idx;
                if (first_bit) begin
                    mode_q <= mode;
                end
            end
        end
    end

`ifdef SERIAL_TC_PAR_OUT_EN
    // Negating 100..0 overflows: the MSB is the first '1' seen in a negated word.
    logic [CHANNELS-1:0] msb_ovf;
    assign msb_ovf = {CHANNELS{mode_eff}} & ~seen_prev & i;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_par
        // Low WIDTH-1 result bits, shifted in from the top so bit 0 lands at position 0.
        logic [WIDTH-2:0] asm_q;
        logic [WIDTH-1:0] word_q;
        logic             ovf_q;

        always_ff @(posedge t_clk) begin
            if (!r) begin
                asm_q  <= '0;
                word_q <= '0;
                ovf_q  <= 1'b0;
            end else if (in_valid) begin
                asm_q <= (asm_q >> 1) | ((WIDTH-1)'(y_next[c]) << (WIDTH - 2));
                if (last_bit) begin
                    word_q <= {y_next[c], asm_q};
                    ovf_q  <= msb_ovf[c];
                end
            end
        end

        assign par_out[c*WIDTH +: WIDTH] = word_q;
        assign ovf[c]                    = ovf_q;
    end
`endif

endmodule

// File: tb/tb_serial_twos_comp_n.sv
// Self-checking bench for serial_twos_comp_n (WIDTH=8, CHANNELS=2) against a whole-word
// arithmetic reference; covers par_out/ovf when SERIAL_TC_PAR_OUT_EN is defined.
module tb_serial_twos_comp_n;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int CNT_W    = $clog2(WIDTH);
    localparam int REC_W    = 2 + CNT_W + CHANNELS;

    // Observed/expected record per output cycle: {out_valid, word_done, bit_idx, y}.
    typedef logic [REC_W-1:0] rec_t;

    logic                t_clk = 1'b0;
    logic                r = 1'b0;
    logic [CHANNELS-1:0] i = '0;
    logic                in_valid = 1'b0;
    logic                sof = 1'b0;
    logic                mode = 1'b0;
    logic [CHANNELS-1:0] y;
    logic                out_valid;
    logic [CNT_W-1:0]    bit_idx;
    logic                word_done;
`ifdef SERIAL_TC_PAR_OUT_EN
    logic [CHANNELS*WIDTH-1:0] par_out;
    logic [CHANNELS-1:0]       ovf;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    logic [REC_W-1:0] exp_q[$];

    serial_twos_comp_n #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .t_clk    (t_clk),
        .r        (r),
        .i        (i),
        .in_valid (in_valid),
        .sof      (sof),
        .mode     (mode),
        .y        (y),
        .out_valid(out_valid),
        .bit_idx  (bit_idx),
`ifdef SERIAL_TC_PAR_OUT_EN
        .word_done(word_done),
        .par_out  (par_out),
        .ovf      (ovf)
`else
        .word_done(word_done)
`endif
    );

    always #5 t_clk = ~t_clk;

    // Reference: the whole word negated modulo 2^WIDTH, or copied.
    function automatic logic [WIDTH-1:0] ref_word(input logic [WIDTH-1:0] w, input logic neg);
        logic [WIDTH-1:0] z;
        z = '0;
        return neg ? z - w : w;
    endfunction

    function automatic rec_t obs();
        return {out_valid, word_done, bit_idx, y};
    endfunction

    task automatic push_word(input logic [WIDTH-1:0] r0, input logic [WIDTH-1:0] r1);
        for (int k = 0; k < WIDTH; k++) begin
            exp_q.push_back({1'b1, (k == WIDTH - 1), CNT_W'(k), r1[k], r0[k]});
        end
    endtask

    task automatic step(input logic [CHANNELS-1:0] bits, input logic v, input logic s,
                        input logic m);
        i        = bits;
        in_valid = v;
        sof      = s;
        mode     = m;
        @(posedge t_clk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                             input logic m0, input int flip_at, input logic use_sof,
                             output rec_t got [WIDTH]);
        for (int k = 0; k < WIDTH; k++) begin
            logic m;
            m = (flip_at >= 0 && k >= flip_at) ? ~m0 : m0;
            step({w1[k], w0[k]}, 1'b1, use_sof && (k == 0), m);
            got[k] = obs();
        end
    endtask

    task automatic test_reset();
        r = 1'b0;
        step(2'b11, 1'b1, 1'b1, 1'b1);
        step(2'b11, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs() !== '0) $display("FAIL reset_outputs got=%b exp=%b", obs(), rec_t'(0));
        else n_pass++;
`ifdef SERIAL_TC_PAR_OUT_EN
        n_checks++;
        if ({par_out, ovf} !== '0) $display("FAIL reset_par got=%h/%b exp=0", par_out, ovf);
        else n_pass++;
`endif
        r = 1'b1;
        step(2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_spec_vector();
        rec_t got [WIDTH];
        push_word(ref_word(8'h06, 1'b1), ref_word(8'h01, 1'b1));
        send_word(8'h06, 8'h01, 1'b1, -1, 1'b1, got);
        for (int k = 0; k < WIDTH; k++) begin
            rec_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (got[k] !== e) $display("FAIL spec_vector bit%0d got=%b exp=%b", k, got[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        rec_t got [WIDTH];
        logic [WIDTH-1:0] words [2];
        words[0] = 8'h00;
        words[1] = 8'h80;
        for (int n = 0; n < 2; n++) begin
            push_word(ref_word(words[n], 1'b1), ref_word(words[n], 1'b1));
            send_word(words[n], words[n], 1'b1, -1, (n == 0), got);
            for (int k = 0; k < WIDTH; k++) begin
                rec_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (got[k] !== e) $display("FAIL b2b w%0d bit%0d got=%b exp=%b", n, k, got[k], e);
                else n_pass++;
            end
`ifdef SERIAL_TC_PAR_OUT_EN
            n_checks++;
            if (par_out !== {2{ref_word(words[n], 1'b1)}} || ovf !== {2{(words[n] == 8'h80)}})
                $display("FAIL b2b_par w%0d got=%h/%b exp=%h/%b", n, par_out, ovf,
                         {2{ref_word(words[n], 1'b1)}}, {2{(words[n] == 8'h80)}});
            else n_pass++;
`endif
        end
    endtask

    task automatic test_mode_latch();
        rec_t got [WIDTH];
        logic [WIDTH-1:0] w1;
        w1 = WIDTH'($urandom_range(0, 255));
        push_word(ref_word(8'h5A, 1'b0), ref_word(w1, 1'b0));
        send_word(8'h5A, w1, 1'b0, 3, 1'b1, got);
        for (int k = 0; k < WIDTH; k++) begin
            rec_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (got[k] !== e) $display("FAIL mode_latch bit%0d got=%b exp=%b", k, got[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_valid_gap();
        logic [WIDTH-1:0] w1, r0, r1;
        w1 = WIDTH'($urandom_range(0, 255));
        r0 = ref_word(8'h06, 1'b1);
        r1 = ref_word(w1, 1'b1);
        for (int k = 0; k < WIDTH; k++) begin
            rec_t e;
            step({w1[k], 1'(8'h06 >> k)}, 1'b1, (k == 0), 1'b1);
            e = {1'b1, (k == WIDTH - 1), CNT_W'(k), r1[k], r0[k]};
            n_checks++;
            if (obs() !== e) $display("FAIL gap_word bit%0d got=%b exp=%b", k, obs(), e);
            else n_pass++;
            if (k == 2) begin
                for (int g = 0; g < 3; g++) begin
                    step(CHANNELS'($urandom_range(0, 3)), 1'b0, 1'b1, 1'($urandom_range(0, 1)));
                    e = {1'b0, 1'b0, CNT_W'(2), r1[2], r0[2]};
                    n_checks++;
                    if (obs() !== e) $display("FAIL gap_hold cyc%0d got=%b exp=%b", g, obs(), e);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_sof_abort();
        rec_t got [WIDTH];
        logic [WIDTH-1:0] a0, a1;
        a0 = WIDTH'($urandom_range(0, 255));
        a1 = WIDTH'($urandom_range(0, 255));
        for (int k = 0; k < 4; k++) begin
            step({a1[k], a0[k]}, 1'b1, (k == 0), 1'b1);
            n_checks++;
            if (word_done !== 1'b0 || bit_idx !== CNT_W'(k))
                $display("FAIL abort_part bit%0d got=%b/%0d exp=0/%0d", k, word_done, bit_idx, k);
            else n_pass++;
        end
        push_word(ref_word(8'h03, 1'b1), ref_word(8'h03, 1'b1));
        send_word(8'h03, 8'h03, 1'b1, -1, 1'b1, got);
        for (int k = 0; k < WIDTH; k++) begin
            rec_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (got[k] !== e) $display("FAIL sof_abort bit%0d got=%b exp=%b", k, got[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midword();
        rec_t got [WIDTH];
        logic [WIDTH-1:0] w1;
        for (int k = 0; k < 5; k++) begin
            step(CHANNELS'($urandom_range(0, 3)), 1'b1, (k == 0), 1'b1);
        end
        r = 1'b0;
        step(2'b11, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs() !== '0) $display("FAIL reset_mid got=%b exp=%b", obs(), rec_t'(0));
        else n_pass++;
        r = 1'b1;
        w1 = WIDTH'($urandom_range(0, 255));
        push_word(ref_word(8'h06, 1'b1), ref_word(w1, 1'b1));
        send_word(8'h06, w1, 1'b1, -1, 1'b0, got);
        for (int k = 0; k < WIDTH; k++) begin
            rec_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (got[k] !== e) $display("FAIL post_reset bit%0d got=%b exp=%b", k, got[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        rec_t got [WIDTH];
        logic [WIDTH-1:0] w [CHANNELS];
        logic m;
        for (int n = 0; n < 24; n++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                case ($urandom_range(0, 5))
                    0:       w[c] = 8'h80;
                    1:       w[c] = 8'h00;
                    default: w[c] = WIDTH'($urandom_range(0, 255));
                endcase
            end
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                step(CHANNELS'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)), ~m);
                n_checks++;
                if (out_valid !== 1'b0 || word_done !== 1'b0)
                    $display("FAIL rand_idle n%0d got=%b%b exp=00", n, out_valid, word_done);
                else n_pass++;
            end
            push_word(ref_word(w[0], m), ref_word(w[1], m));
            send_word(w[0], w[1], m, -1, 1'($urandom_range(0, 1)), got);
            for (int k = 0; k < WIDTH; k++) begin
                rec_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (got[k] !== e) $display("FAIL rand n%0d bit%0d got=%b exp=%b", n, k, got[k], e);
                else n_pass++;
            end
`ifdef SERIAL_TC_PAR_OUT_EN
            n_checks++;
            if (par_out !== {ref_word(w[1], m), ref_word(w[0], m)} ||
                ovf !== {m && (w[1] == 8'h80), m && (w[0] == 8'h80)})
                $display("FAIL rand_par n%0d got=%h/%b exp=%h/%b", n, par_out, ovf,
                         {ref_word(w[1], m), ref_word(w[0], m)},
                         {m && (w[1] == 8'h80), m && (w[0] == 8'h80)});
            else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_spec_vector();
        test_back_to_back();
        test_mode_latch();
        test_valid_gap();
        test_sof_abort();
        test_reset_midword();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_twos_comp_n.md
Name: serial_twos_comp_n

Overview:
- Parametrised, multi-channel, bit-serial two's complementer. Each channel takes one LSB-first serial word per frame and emits its two's complement (or a pass-through copy) one bit per valid cycle.
- Serial rule: each output bit equals the input bit up to and including the first '1'; every later bit is the inverted input bit.
- Successor to the single-channel, free-running serial inverter. Adds word framing, valid qualification, mode select, per-word status and realignment.
- Sits between serial sources and downstream bit-serial arithmetic.

Parameters:
- WIDTH, 8, bits per serial word (>=2); frame length in valid cycles.
- CHANNELS, 1, number of independent serial lanes sharing one framing counter.
- CNT_W, $clog2(WIDTH), width of bit counter (derived; not overridden).

Ports:
- t_clk  input  1  clock; all logic on rising edge.
- r  input  1  reset, synchronous, active-low.
- i  input  CHANNELS  serial data bits, one per channel, LSB first.
- in_valid  input  1  qualifies i; state advances only when high.
- sof  input  1  start-of-frame; with in_valid, forces the current bit to be bit 0.
- mode  input  1  1 = negate (two's complement), 0 = pass-through.
- y  output  CHANNELS  registered serial result bits.
- out_valid  output  1  y holds a result bit.
- bit_idx  output  CNT_W  index of the bit currently on y.
- word_done  output  1  one-cycle pulse with the last (MSB) output bit of a word.

Behaviour:
- Reset (r low at clock edge) clears all of the following, overriding every other input:
  - y=0, out_valid=0, word_done=0, bit_idx=0.
  - Internal bit counter = 0, per-channel seen_one flags = 0, latched mode = 0.
- Latency: 1 cycle. Bit sampled at edge k appears on y after edge k, with out_valid=1.
- in_valid low: out_valid=0, word_done=0. y, bit_idx, counter, seen_one and latched mode all hold.
- Bit index for the current valid bit: 0 if sof=1, otherwise the counter value.
- At bit 0, mode is latched and used for the whole word; mode changes mid-word are ignored.
- Per channel c on a valid bit:
  - seen_prev = 0 if index 0, else seen_one[c].
  - If latched mode is negate and seen_prev = 1: y[c] <= ~i[c]; otherwise y[c] <= i[c].
  - seen_one[c] <= seen_prev | i[c].
- Counter: increments on each valid bit. At index WIDTH-1 it wraps to 0, word_done pulses with that bit's output, and seen_one is cleared.
- sof on a valid bit mid-word: the partial word is abandoned without a word_done pulse, and the counter restarts so the next bit is index 1.
- sof together with the natural wrap: same result; no double pulse.
- Channels are fully independent apart from the shared counter, mode and framing.
- Negating the most-negative value (100…0) yields the same value. This is not an error in the base block.
- Negating zero yields zero.
- Reset mid-word discards the word; the next valid bit is index 0.

Optional Feature:
- Macro: SERIAL_TC_PAR_OUT_EN.
- Defined: adds output ports par_out [CHANNELS*WIDTH] and ovf [CHANNELS].
  - par_out: each channel's assembled result word, updated in the same cycle as word_done and held until the next word_done.
  - ovf[c]: set when mode=negate and the input word is exactly 1 followed by WIDTH-1 zeros (MSB-first notation). Detected at the MSB bit as seen_prev=0 with i[c]=1; updated with word_done.
  - par_out=0 and ovf=0 on reset.
- Undefined: neither port exists; no assembly registers or overflow logic.

Test Plan:
- WIDTH=8, CHANNELS=2, mode=1, sof at bit 0. ch0 = 0x06 (LSB-first 0,1,1,0,0,0,0,0), ch1 = 0x01. Required: ch0 y = 0,1,0,1,1,1,1,1 (0xFA); ch1 = 0xFF; word_done exactly on the 8th output bit.
- mode=1, input 0x00, then back-to-back 0x80 with no idle cycles. Required: 0x00, then 0x80. With SERIAL_TC_PAR_OUT_EN: ovf=0, then ovf=1; par_out = 0x00, then 0x80.
- mode=0, input 0x5A with mode toggled to 1 at bit 3. Required: output 0x5A unchanged (mode latched at bit 0).
- 0x06 negate with in_valid low for 3 cycles after bit 2. Required: out_valid=0 and y held during the gap; final word 0xFA; bit_idx sequence 0..7 unbroken.
- sof asserted at bit 4 of a word, then 0x03 sent. Required: no word_done for the aborted word; next word yields 0xFD.
- r low for 1 cycle at bit 5 of a word. Required: the next cycle shows y=0, out_valid=0, word_done=0. A fresh word 0x06 then gives 0xFA.
